// File: rtl/wash_phase_timer.sv
// wash_phase_timer: per-phase countdown timer for the washing-machine cycle FSM.
// Loads a phase duration (seconds) on a phase-code change, counts it down on a
// divided one-second tick and pulses Time_Event once when the phase runs out.
// Optional feature macro WASH_TIMER_PAUSE_HOLD_EN: when defined, a spin can be
// paused and later resumed with its remaining time intact; when undefined,
// Pause_Enable is ignored and Paused is held at 0.
module wash_phase_timer #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter logic [7:0]  FILL_SEC  = 8'd60,
  parameter logic [7:0]  WASH_SEC  = 8'd120,
  parameter logic [7:0]  RINSE_SEC = 8'd60,
  parameter logic [7:0]  SPIN_SEC  = 8'd60
) (
  input  logic       Clk_D,
  input  logic       Rst,
  input  logic [2:0] Timer_Encoding,
  input  logic       Pause_Enable,
  output logic       Time_Event,
  output logic [7:0] Remaining,
  output logic       Phase_Active,
  output logic       Paused
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_EXPIRED, S_PAUSED} state_e;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  // A zero-second phase would never expire, so it is stretched to one second.
  function automatic logic [7:0] sat_dur(input logic [7:0] sec);
    return (sec == 8'd0) ? 8'd1 : sec;
  endfunction

  function automatic logic [7:0] phase_dur(input logic [2:0] enc);
    case (enc)
      3'd1:    return sat_dur(FILL_SEC);
      3'd2:    return sat_dur(WASH_SEC);
      3'd3:    return sat_dur(RINSE_SEC);
      3'd4:    return sat_dur(SPIN_SEC);
      default: return 8'd1;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  prev_enc_q;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  rem_q, rem_d;
  logic        tev_q, tev_d;

  logic is_phase, load_req, tick;

  assign is_phase = (Timer_Encoding >= 3'd1) && (Timer_Encoding <= 3'd4);
  assign load_req = is_phase && (Timer_Encoding != prev_enc_q);
  assign tick     = (presc_q == TICK_LAST);

`ifndef WASH_TIMER_PAUSE_HOLD_EN
  logic unused_pause;
  assign unused_pause = Pause_Enable;
`endif

  // Next-state logic: phase loads, countdown, expiry, pause hold and resume.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    tev_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          rem_d   = phase_dur(Timer_Encoding);
          presc_d = 16'd0;
          state_d = S_COUNT;
        end else begin
          rem_d   = 8'd0;
          presc_d = 16'd0;
        end
      end
      S_COUNT: begin
        if (load_req) begin
          // Mid-phase code change (e.g. Rinsing back to Washing) reloads silently.
          rem_d   = phase_dur(Timer_Encoding);
          presc_d = 16'd0;
        end else if (!is_phase) begin
          rem_d   = 8'd0;
          presc_d = 16'd0;
          state_d = S_IDLE;
`ifdef WASH_TIMER_PAUSE_HOLD_EN
        end else if ((Timer_Encoding == 3'd4) && Pause_Enable) begin
          // Pause wins over a coincident tick; both counters freeze as they are.
          state_d = S_PAUSED;
`endif
        end else if (tick) begin
          presc_d = 16'd0;
          if (rem_q == 8'd1) begin
            rem_d   = 8'd0;
            tev_d   = 1'b1;
            state_d = S_EXPIRED;
          end else if (rem_q != 8'd0) begin
            rem_d = rem_q - 8'd1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
      S_EXPIRED: begin
        rem_d   = 8'd0;
        presc_d = 16'd0;
        if (load_req) begin
          rem_d   = phase_dur(Timer_Encoding);
          state_d = S_COUNT;
        end else if (!is_phase) begin
          state_d = S_IDLE;
        end
      end
`ifdef WASH_TIMER_PAUSE_HOLD_EN
      S_PAUSED: begin
        if (Timer_Encoding == 3'd0) begin
          state_d = S_PAUSED;
        end else if (Timer_Encoding == 3'd4) begin
          // Resume the held spin; counting restarts on the following edge.
          state_d = S_COUNT;
        end else if (is_phase) begin
          rem_d   = phase_dur(Timer_Encoding);
          presc_d = 16'd0;
          state_d = S_COUNT;
        end else begin
          rem_d   = 8'd0;
          presc_d = 16'd0;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        rem_d   = 8'd0;
        presc_d = 16'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge Clk_D) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      prev_enc_q <= 3'd0;
      presc_q    <= 16'd0;
      rem_q      <= 8'd0;
      tev_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_enc_q <= Timer_Encoding;
      presc_q    <= presc_d;
      rem_q      <= rem_d;
      tev_q      <= tev_d;
    end
  end

  assign Time_Event   = tev_q;
  assign Remaining    = rem_q;
  assign Phase_Active = (state_q == S_COUNT);
`ifdef WASH_TIMER_PAUSE_HOLD_EN
  assign Paused       = (state_q == S_PAUSED);
`else
  assign Paused       = 1'b0;
`endif

endmodule

// File: tb/tb_wash_phase_timer.sv
// Testbench for wash_phase_timer: directed phase scenarios plus randomized
// stimulus checked against a cycles-left reference model.
module tb_wash_phase_timer;

  localparam int T = 4;
`ifdef WASH_TIMER_PAUSE_HOLD_EN
  localparam bit PH = 1'b1;
`else
  localparam bit PH = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] enc;
  logic       pe;
  logic       tev, act, paused;
  logic [7:0] rem;
  logic       tev2, act2, paused2;
  logic [7:0] rem2;

  int checks   = 0;
  int failures = 0;

  wash_phase_timer #(.TICK_DIV(T), .FILL_SEC(8'd3), .WASH_SEC(8'd5),
                     .RINSE_SEC(8'd2), .SPIN_SEC(8'd4)) dut (
    .Clk_D(clk), .Rst(rst), .Timer_Encoding(enc), .Pause_Enable(pe),
    .Time_Event(tev), .Remaining(rem), .Phase_Active(act), .Paused(paused));

  wash_phase_timer #(.TICK_DIV(T), .FILL_SEC(8'd3), .WASH_SEC(8'd0),
                     .RINSE_SEC(8'd2), .SPIN_SEC(8'd4)) dut0 (
    .Clk_D(clk), .Rst(rst), .Timer_Encoding(enc), .Pause_Enable(pe),
    .Time_Event(tev2), .Remaining(rem2), .Phase_Active(act2), .Paused(paused2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the phase is tracked as clock cycles left until expiry.
  // mode: 0 idle, 1 running, 2 expired, 3 held (paused)
  int         m_mode = 0;
  int         m_left = 0;
  logic [2:0] m_prev = 3'd0;
  logic       m_tev  = 1'b0;

  function automatic int dur_sec(input logic [2:0] e);
    case (e)
      3'd1: return 3;
      3'd2: return 5;
      3'd3: return 2;
      3'd4: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int m_rem();
    return (m_left + T - 1) / T;
  endfunction

  task automatic model_step();
    bit ph, chg;
    m_tev = 1'b0;
    if (!rst) begin
      m_mode = 0; m_left = 0; m_prev = 3'd0;
    end else begin
      ph  = (enc >= 3'd1) && (enc <= 3'd4);
      chg = (enc != m_prev);
      if (m_mode == 3) begin
        if (enc == 3'd0) m_mode = 3;
        else if (enc == 3'd4) m_mode = 1;
        else if (ph) begin m_left = dur_sec(enc) * T; m_mode = 1; end
        else begin m_left = 0; m_mode = 0; end
      end else if (ph && chg) begin
        m_left = dur_sec(enc) * T; m_mode = 1;
      end else if (!ph) begin
        m_left = 0; m_mode = 0;
      end else if (m_mode == 1) begin
        if (PH && enc == 3'd4 && pe) m_mode = 3;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_tev = 1'b1; m_mode = 2; end
        end
      end
      m_prev = enc;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; enc = 3'd0; pe = 1'b0;
    cyc(); cyc();
    checks++; if (tev !== 1'b0) begin failures++; $display("FAIL reset_tev got=%0d exp=0", tev); end
    checks++; if (rem !== 8'd0) begin failures++; $display("FAIL reset_rem got=%0d exp=0", rem); end
    checks++; if (act !== 1'b0) begin failures++; $display("FAIL reset_act got=%0d exp=0", act); end
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL reset_paused got=%0d exp=0", paused); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_fill();
    enc = 3'd0; cyc();
    enc = 3'd1; cyc();
    checks++; if (rem !== 8'd3) begin failures++; $display("FAIL fill_load_rem got=%0d exp=3", rem); end
    checks++; if (act !== 1'b1) begin failures++; $display("FAIL fill_act got=%0d exp=1", act); end
    repeat (4) cyc();
    checks++; if (rem !== 8'd2) begin failures++; $display("FAIL fill_rem_L4 got=%0d exp=2", rem); end
    repeat (4) cyc();
    checks++; if (rem !== 8'd1) begin failures++; $display("FAIL fill_rem_L8 got=%0d exp=1", rem); end
    for (int i = 9; i <= 11; i++) begin
      cyc();
      checks++; if (tev !== 1'b0) begin failures++; $display("FAIL fill_early_tev cyc=%0d got=%0d exp=0", i, tev); end
    end
    cyc();
    checks++; if (tev !== 1'b1) begin failures++; $display("FAIL fill_tev_L12 got=%0d exp=1", tev); end
    checks++; if (rem !== 8'd0) begin failures++; $display("FAIL fill_rem_L12 got=%0d exp=0", rem); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (tev !== 1'b0) begin failures++; $display("FAIL fill_repulse got=%0d exp=0", tev); end
    end
    checks++; if (act !== 1'b0) begin failures++; $display("FAIL fill_expired_act got=%0d exp=0", act); end
    enc = 3'd0; cyc();
  endtask

  task automatic test_mid_change();
    int got;
    enc = 3'd0; cyc();
    enc = 3'd2; cyc();
    checks++; if (rem !== 8'd5) begin failures++; $display("FAIL mid_wash_rem got=%0d exp=5", rem); end
    repeat (5) cyc();
    enc = 3'd3; cyc();
    checks++; if (rem !== 8'd2) begin failures++; $display("FAIL mid_rinse_rem got=%0d exp=2", rem); end
    checks++; if (tev !== 1'b0) begin failures++; $display("FAIL mid_tev got=%0d exp=0", tev); end
    got = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (tev === 1'b1) begin got = i; break; end
    end
    checks++; if (got != 8) begin failures++; $display("FAIL mid_pulse_delay got=%0d exp=8", got); end
    enc = 3'd0; cyc();
  endtask

  task automatic test_pause();
    int got;
    int exp_delay;
    enc = 3'd0; pe = 1'b0; cyc(); cyc();
    enc = 3'd4; cyc();
    checks++; if (rem !== 8'd4) begin failures++; $display("FAIL pause_load_rem got=%0d exp=4", rem); end
    repeat (8) cyc();
    checks++; if (rem !== 8'd2) begin failures++; $display("FAIL pause_pre_rem got=%0d exp=2", rem); end
    pe = 1'b1; cyc();
    pe = 1'b0; enc = 3'd0;
    checks++; if (paused !== PH) begin failures++; $display("FAIL pause_edge_paused got=%0d exp=%0d", paused, PH); end
    checks++; if (rem !== 8'd2) begin failures++; $display("FAIL pause_edge_rem got=%0d exp=2", rem); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (paused !== PH) begin failures++; $display("FAIL pause_hold_paused cyc=%0d got=%0d exp=%0d", i, paused, PH); end
      checks++; if (rem !== (PH ? 8'd2 : 8'd0)) begin failures++; $display("FAIL pause_hold_rem cyc=%0d got=%0d exp=%0d", i, rem, (PH ? 2 : 0)); end
    end
    enc = 3'd4; cyc();
    checks++; if (rem !== (PH ? 8'd2 : 8'd4)) begin failures++; $display("FAIL pause_resume_rem got=%0d exp=%0d", rem, (PH ? 2 : 4)); end
    checks++; if (act !== 1'b1) begin failures++; $display("FAIL pause_resume_act got=%0d exp=1", act); end
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL pause_resume_paused got=%0d exp=0", paused); end
    exp_delay = PH ? 8 : 16;
    got = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (tev === 1'b1) begin got = i; break; end
    end
    checks++; if (got != exp_delay) begin failures++; $display("FAIL pause_pulse_delay got=%0d exp=%0d", got, exp_delay); end
    enc = 3'd0; cyc();
  endtask

  task automatic test_reset_mid();
    enc = 3'd0; cyc();
    enc = 3'd1; cyc(); cyc();
    checks++; if (rem !== 8'd3) begin failures++; $display("FAIL rstmid_pre_rem got=%0d exp=3", rem); end
    rst = 1'b0; enc = 3'd0; cyc();
    checks++; if (rem !== 8'd0) begin failures++; $display("FAIL rstmid_rem got=%0d exp=0", rem); end
    checks++; if (act !== 1'b0) begin failures++; $display("FAIL rstmid_act got=%0d exp=0", act); end
    checks++; if (tev !== 1'b0) begin failures++; $display("FAIL rstmid_tev got=%0d exp=0", tev); end
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL rstmid_paused got=%0d exp=0", paused); end
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++; if (tev !== 1'b0 || rem !== 8'd0) begin failures++; $display("FAIL rstmid_after cyc=%0d tev=%0d rem=%0d exp tev=0 rem=0", i, tev, rem); end
    end
  endtask

  task automatic test_zero_dur();
    int got;
    enc = 3'd0; cyc();
    enc = 3'd2; cyc();
    checks++; if (rem2 !== 8'd1) begin failures++; $display("FAIL zero_rem got=%0d exp=1", rem2); end
    checks++; if (rem !== 8'd5) begin failures++; $display("FAIL zero_ref_rem got=%0d exp=5", rem); end
    got = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (tev2 === 1'b1) begin got = i; break; end
    end
    checks++; if (got != 4) begin failures++; $display("FAIL zero_pulse_delay got=%0d exp=4", got); end
    checks++; if (rem2 !== 8'd0) begin failures++; $display("FAIL zero_pulse_rem got=%0d exp=0", rem2); end
    enc = 3'd0; cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 2) == 0) enc = 3'd4;
        else enc = 3'($urandom_range(0, 7));
      end
      pe  = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) != 0);
      cyc();
      checks++; if (tev !== m_tev) begin failures++; $display("FAIL rand_tev cyc=%0d got=%0d exp=%0d", i, tev, m_tev); end
      checks++; if (rem !== 8'(m_rem())) begin failures++; $display("FAIL rand_rem cyc=%0d got=%0d exp=%0d", i, rem, m_rem()); end
      checks++; if (act !== (m_mode == 1)) begin failures++; $display("FAIL rand_act cyc=%0d got=%0d exp=%0d", i, act, (m_mode == 1)); end
      checks++; if (paused !== (m_mode == 3)) begin failures++; $display("FAIL rand_paused cyc=%0d got=%0d exp=%0d", i, paused, (m_mode == 3)); end
    end
    rst = 1'b1; pe = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enc = 3'd0; pe = 1'b0;
    test_reset();
    test_fill();
    test_mid_change();
    test_pause();
    test_reset_mid();
    test_zero_dur();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
